// File: rtl/digit_scanner.sv
// Time-multiplexed 7-segment digit scanner with per-slot dead time,
// leading-zero blanking and frame-aligned (tear-free) value updates.
module digit_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 8,
    parameter int LZB_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_start
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_active;
    logic                r_pending;

    logic                w_wrap;
    logic                w_boundary;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [4*DIGITS-1:0] w_active_nxt;
    logic [DIGITS-1:0]   w_zero_above;
    logic                w_zacc;
    logic                w_lit;
    logic [3:0]          w_bcd_nxt;
    logic [DIGITS-1:0]   w_en_nxt;
    logic                w_fs_nxt;

    always_comb begin
        w_wrap     = (r_cnt == LAST_CNT);
        w_boundary = w_wrap && (r_idx == LAST_IDX);
        w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_nxt  = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end

        // A load on the boundary edge itself bypasses the shadow register.
        w_active_nxt = r_active;
        if (w_boundary) begin
            if (load) begin
                w_active_nxt = value;
            end else if (r_pending) begin
                w_active_nxt = r_shadow;
            end
        end

        // w_zero_above[i]: nibbles i..DIGITS-1 of the next active value are all zero.
        w_zero_above = '0;
        w_zacc       = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_zacc = w_zacc && (w_active_nxt[4*(DIGITS-1-k) +: 4] == 4'h0);
            w_zero_above[DIGITS-1-k] = w_zacc;
        end

        w_lit     = (BLANK == 0) || (w_cnt_nxt >= BLANK_C);
        w_bcd_nxt = '0;
        w_en_nxt  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_bcd_nxt   = w_active_nxt[4*i +: 4];
                w_en_nxt[i] = w_lit && !((LZB_EN != 0) && (i != 0) && w_zero_above[i]);
            end
        end

        w_fs_nxt = (w_cnt_nxt == '0) && (w_idx_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_active    <= '0;
            r_pending   <= 1'b0;
            bcd         <= '0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_active <= w_active_nxt;
            if (load) begin
                r_shadow <= value;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            bcd         <= w_bcd_nxt;
            dig_en      <= w_en_nxt;
            frame_start <= w_fs_nxt;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: directed scenarios plus random loads, checked every
// cycle against a frame-arithmetic reference model (LZB on and off instances).
module tb_digit_scanner;

    localparam int D     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = D * P;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    bcd1, bcd0;
    logic [D-1:0]  en1, en0;
    logic          fs1, fs0;

    int total = 0;
    int bad   = 0;

    int unsigned n;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pend;

    always #5 clk = ~clk;

    digit_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK(B), .LZB_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .bcd(bcd1), .dig_en(en1), .frame_start(fs1)
    );

    digit_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK(B), .LZB_EN(0)) dut_nolzb (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .bcd(bcd0), .dig_en(en0), .frame_start(fs0)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_active = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bcd"}, {12'h0, bcd1}, 16'h0);
        chk({tag, "_en"},  {12'h0, en1},  16'h0);
        chk({tag, "_fs"},  {15'h0, fs1},  16'h0);
        chk({tag, "_en0"}, {12'h0, en0},  16'h0);
    endtask

    // One clock edge: apply inputs, advance the model, check both instances.
    task automatic step(input bit ld, input logic [15:0] v);
        int unsigned cnt, idx;
        logic [15:0] upper;
        logic [D-1:0] e1, e0;
        @(negedge clk);
        load  = ld;
        value = v;
        @(posedge clk);
        n++;
        if (n % FRAME == 0) begin
            if (ld) m_active = v;
            else if (m_pend) m_active = m_shadow;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) m_shadow = v;
        cnt   = n % P;
        idx   = (n / P) % D;
        upper = m_active >> (4 * idx);
        e1 = '0;
        e0 = '0;
        if (cnt >= B) begin
            e0[idx] = 1'b1;
            if (idx == 0 || upper != 0) e1[idx] = 1'b1;
        end
        #1;
        chk("bcd",     {12'h0, bcd1}, {12'h0, upper[3:0]});
        chk("dig_en",  {12'h0, en1},  {12'h0, e1});
        chk("fs",      {15'h0, fs1},  {15'h0, (n % FRAME == 0)});
        chk("bcd_nolzb",    {12'h0, bcd0}, {12'h0, upper[3:0]});
        chk("dig_en_nolzb", {12'h0, en0},  {12'h0, e0});
        chk("fs_nolzb",     {15'h0, fs0},  {15'h0, (n % FRAME == 0)});
        load = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 16'h0);
    endtask

    task automatic adv_to(input int unsigned r);
        for (int i = 0; i < FRAME && (n % FRAME) != r; i++) step(1'b0, 16'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_hold");
        rst_n = 1'b1;

        // First lit cycle is the third one after release.
        run(FRAME + 4);

        step(1'b1, 16'h1234);
        run(3 * FRAME);

        step(1'b1, 16'h0005);
        run(2 * FRAME);
        step(1'b1, 16'h0105);
        run(2 * FRAME);
        step(1'b1, 16'h0000);
        run(2 * FRAME);
        step(1'b1, 16'h1234);
        run(FRAME);

        adv_to(9);
        step(1'b1, 16'hABCD);
        run(2 * FRAME);

        adv_to(10);
        step(1'b1, 16'h1111);
        adv_to(FRAME - 1);
        step(1'b1, 16'h2222);
        run(3 * FRAME);

        for (int t = 0; t < 40; t++) begin
            run($urandom_range(0, 40));
            step(1'b1, 16'($urandom));
            if ($urandom_range(0, 3) == 0) step(1'b1, 16'($urandom));
        end
        run(2 * FRAME);

        // Asynchronous reset mid-slot (idx=2, cnt=5).
        step(1'b1, 16'h9876);
        run(2 * FRAME);
        adv_to(2 * P + 5);
        rst_n = 1'b0;
        #1;
        chk_zero("reset_async");
        @(posedge clk);
        #1;
        chk_zero("reset_hold2");
        rst_n = 1'b1;
        model_reset();
        run(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
